dmi_arbiter: RTL and testbench

- Shares the single DMI port of dm_top between two DTM front-ends: UART channel 0 and UART channel 1, each producing 41-bit DMI requests.
- Round-robin arbitration with exactly one outstanding transaction at a time.
- Responses are routed back to the requester that issued the request.
- Sits between the DTM_UART channel datapaths and dm_top; runs entirely in the clk domain.

---
 rtl/dmi_arbiter_if.sv | 50 +++++
 rtl/dmi_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmi_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_arbiter_if.sv
// DMI arbiter bus bundle: two DTM channel request/response ports, the dm_top port and status.
// The arbiter uses the slave modport; the surrounding logic (channels + dm_top) uses master.
interface dmi_arbiter_if #(
    parameter int REQ_WIDTH  = 41,
    parameter int RESP_WIDTH = 34
);
    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic [REQ_WIDTH-1:0]  req0_i;
    logic                  resp0_valid_o;
    logic                  resp0_ready_i;
    logic [RESP_WIDTH-1:0] resp0_o;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic [REQ_WIDTH-1:0]  req1_i;
    logic                  resp1_valid_o;
    logic                  resp1_ready_i;
    logic [RESP_WIDTH-1:0] resp1_o;

    logic                  dmi_req_valid_o;
    logic                  dmi_req_ready_i;
    logic [REQ_WIDTH-1:0]  dmi_req_o;
    logic                  dmi_resp_valid_i;
    logic                  dmi_resp_ready_o;
    logic [RESP_WIDTH-1:0] dmi_resp_i;

    logic                  busy_o;
    logic                  owner_o;

    modport slave (
        input  req0_valid_i, req0_i, resp0_ready_i,
        input  req1_valid_i, req1_i, resp1_ready_i,
        input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_i,
        output req0_ready_o, resp0_valid_o, resp0_o,
        output req1_ready_o, resp1_valid_o, resp1_o,
        output dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o,
        output busy_o, owner_o
    );

    modport master (
        output req0_valid_i, req0_i, resp0_ready_i,
        output req1_valid_i, req1_i, resp1_ready_i,
        output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_i,
        input  req0_ready_o, resp0_valid_o, resp0_o,
        input  req1_ready_o, resp1_valid_o, resp1_o,
        input  dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o,
        input  busy_o, owner_o
    );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the dm_top DMI port between two DTM channels, one transaction at a time.
// Define DMI_ARB_TIMEOUT_EN to add a response watchdog that returns a DMI "failed" response.
//
// state   | meaning
// IDLE    | no transaction; grant a requesting channel combinationally
// REQ     | presenting the captured request to dm_top
// RESP    | waiting for dm_top's response
// DELIVER | presenting the response to the owning channel
module dmi_arbiter #(
    parameter int REQ_WIDTH      = 41,
    parameter int RESP_WIDTH     = 34,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    dmi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("dmi_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_t                state;
    logic                  last_grant;
    logic [REQ_WIDTH-1:0]  dmi_req_q;
    logic                  dmi_req_valid_q;
    logic                  dmi_resp_ready_q;
    logic [RESP_WIDTH-1:0] resp0_q;
    logic [RESP_WIDTH-1:0] resp1_q;
    logic                  resp0_valid_q;
    logic                  resp1_valid_q;

    logic                  grant_vld;
    logic                  grant_ch;
    logic                  cap_en;
    logic [RESP_WIDTH-1:0] cap_data;
    logic                  owner_ready;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;
    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Ready is gated by reset so nothing is handed over while reset is being sampled.
    always_comb begin
        grant_vld = reset_n && (state == IDLE) && (bus.req0_valid_i || bus.req1_valid_i);
        grant_ch  = (bus.req0_valid_i && bus.req1_valid_i) ? !last_grant : bus.req1_valid_i;
    end

    // A real response always beats the watchdog when both land on the same cycle.
    always_comb begin
        cap_en   = (state == RESP) && bus.dmi_resp_valid_i;
        cap_data = bus.dmi_resp_i;
`ifdef DMI_ARB_TIMEOUT_EN
        if ((state == RESP) && !bus.dmi_resp_valid_i && to_hit) begin
            cap_en   = 1'b1;
            cap_data = RESP_WIDTH'(2'b10);
        end
`endif
    end

    assign owner_ready = last_grant ? bus.resp1_ready_i : bus.resp0_ready_i;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            last_grant       <= 1'b1;
            dmi_req_q        <= '0;
            dmi_req_valid_q  <= 1'b0;
            dmi_resp_ready_q <= 1'b0;
            resp0_q          <= '0;
            resp1_q          <= '0;
            resp0_valid_q    <= 1'b0;
            resp1_valid_q    <= 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
            to_cnt           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        dmi_req_q       <= grant_ch ? bus.req1_i : bus.req0_i;
                        last_grant      <= grant_ch;
                        dmi_req_valid_q <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (bus.dmi_req_ready_i) begin
                        dmi_req_valid_q  <= 1'b0;
                        dmi_resp_ready_q <= 1'b1;
                        state            <= RESP;
`ifdef DMI_ARB_TIMEOUT_EN
                        to_cnt           <= '0;
`endif
                    end
                end
                RESP: begin
                    if (cap_en) begin
                        dmi_resp_ready_q <= 1'b0;
                        if (last_grant) begin
                            resp1_q       <= cap_data;
                            resp1_valid_q <= 1'b1;
                        end else begin
                            resp0_q       <= cap_data;
                            resp0_valid_q <= 1'b1;
                        end
                        state <= DELIVER;
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                DELIVER: begin
                    if (owner_ready) begin
                        resp0_valid_q <= 1'b0;
                        resp1_valid_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready_o     = grant_vld && !grant_ch;
    assign bus.req1_ready_o     = grant_vld && grant_ch;
    assign bus.dmi_req_valid_o  = dmi_req_valid_q;
    assign bus.dmi_req_o        = dmi_req_q;
    assign bus.dmi_resp_ready_o = dmi_resp_ready_q;
    assign bus.resp0_valid_o    = resp0_valid_q;
    assign bus.resp0_o          = resp0_q;
    assign bus.resp1_valid_o    = resp1_valid_q;
    assign bus.resp1_o          = resp1_q;
    assign bus.busy_o           = (state != IDLE);
    assign bus.owner_o          = last_grant;
endmodule

// File: tb/tb_dmi_arbiter.sv
// Testbench for dmi_arbiter: directed scenarios plus randomized traffic, checked by a scoreboard
// monitor against a transaction-level model of the round-robin, one-outstanding arbiter.
module tb_dmi_arbiter;
    localparam int RW = 41;
    localparam int PW = 34;
`ifdef DMI_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int W_R0 = 0, W_R1 = 1, W_DR = 2, W_IDLE = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmi_arbiter_if #(.REQ_WIDTH(RW), .RESP_WIDTH(PW)) bus();
    dmi_arbiter #(.REQ_WIDTH(RW), .RESP_WIDTH(PW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=unexpected transfer required=none pending", name);
    endtask

    // Transaction model: phase 0 free, 1 request to dm_top, 2 awaiting dm_top, 3 returning to owner.
    int              ph = 0;
    int              rw = 0;
    logic            last = 1'b1;
    logic [RW-1:0]   exp_dmi[$];
    logic [PW-1:0]   exp_r0[$];
    logic [PW-1:0]   exp_r1[$];
    int              acc0 = 0, acc1 = 0, done0 = 0, done1 = 0;

    always @(negedge clk) begin : monitor
        logic v0, v1, egv, eg;
        if (!reset_n) begin
            ph = 0;
            last = 1'b1;
            exp_dmi.delete();
            exp_r0.delete();
            exp_r1.delete();
        end else begin
            v0  = bus.req0_valid_i;
            v1  = bus.req1_valid_i;
            egv = (ph == 0) && (v0 || v1);
            eg  = (v0 && v1) ? !last : v1;
            chk("req_ready", 64'({bus.req1_ready_o, bus.req0_ready_o}), 64'({egv && eg, egv && !eg}));
            chk("busy", 64'(bus.busy_o), 64'(ph != 0));
            chk("owner", 64'(bus.owner_o), 64'(last));
            chk("dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'(ph == 1));
            chk("dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'(ph == 2));
            chk("resp_valids", 64'({bus.resp1_valid_o, bus.resp0_valid_o}),
                64'({ph == 3 && last, ph == 3 && !last}));
            case (ph)
                0: if (egv) begin
                    exp_dmi.push_back(eg ? bus.req1_i : bus.req0_i);
                    last = eg;
                    ph = 1;
                    if (eg) acc1++; else acc0++;
                end
                1: if (bus.dmi_req_valid_o && bus.dmi_req_ready_i) begin
                    if (exp_dmi.size() == 0) fail("dmi_req");
                    else chk("dmi_req", 64'(bus.dmi_req_o), 64'(exp_dmi.pop_front()));
                    ph = 2;
                    rw = 0;
                end
                2: if (bus.dmi_resp_valid_i && bus.dmi_resp_ready_o) begin
                    if (last) exp_r1.push_back(bus.dmi_resp_i);
                    else exp_r0.push_back(bus.dmi_resp_i);
                    ph = 3;
                end else begin
`ifdef DMI_ARB_TIMEOUT_EN
                    rw++;
                    if (rw == TO) begin
                        if (last) exp_r1.push_back(PW'(2'b10));
                        else exp_r0.push_back(PW'(2'b10));
                        ph = 3;
                    end
`endif
                end
                3: begin
                    if (!last && bus.resp0_valid_o && bus.resp0_ready_i) begin
                        if (exp_r0.size() == 0) fail("resp0");
                        else chk("resp0", 64'(bus.resp0_o), 64'(exp_r0.pop_front()));
                        ph = 0;
                        done0++;
                    end
                    if (last && bus.resp1_valid_o && bus.resp1_ready_i) begin
                        if (exp_r1.size() == 0) fail("resp1");
                        else chk("resp1", 64'(bus.resp1_o), 64'(exp_r1.pop_front()));
                        ph = 0;
                        done1++;
                    end
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic wait_for(input int sel, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                W_R0:    hit = bus.req0_ready_o;
                W_R1:    hit = bus.req1_ready_o;
                W_DR:    hit = bus.dmi_resp_ready_o;
                default: hit = !bus.busy_o;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: actual=timeout after 200 cycles required=event", name);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [RW-1:0] r_a, r_b;
    logic [PW-1:0] d_a;
    logic          f0, f1, fr;
    int            a0s, a1s, d0s, d1s, i0, i1, n;

    initial begin
        bus.req0_valid_i = 0; bus.req0_i = '0; bus.resp0_ready_i = 0;
        bus.req1_valid_i = 0; bus.req1_i = '0; bus.resp1_ready_i = 0;
        bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0; bus.dmi_resp_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy_o), 64'(0));
        chk("rst_owner", 64'(bus.owner_o), 64'(1));
        chk("rst_valids", 64'({bus.dmi_req_valid_o, bus.dmi_resp_ready_o, bus.resp0_valid_o,
            bus.resp1_valid_o, bus.req0_ready_o, bus.req1_ready_o}), 64'(0));
        chk("rst_dmi_req", 64'(bus.dmi_req_o), 64'(0));
        chk("rst_resp0", 64'(bus.resp0_o), 64'(0));
        chk("rst_resp1", 64'(bus.resp1_o), 64'(0));
        step();
        reset_n = 1'b1;

        // Single request on channel 0.
        r_a = {7'h11, 32'h0, 2'b01};
        bus.req0_valid_i = 1; bus.req0_i = r_a;
        wait_for(W_R0, "single_accept");
        step();
        bus.req0_valid_i = 0; bus.dmi_req_ready_i = 1;
        @(negedge clk);
        chk("single_dmi_valid", 64'(bus.dmi_req_valid_o), 64'(1));
        chk("single_dmi_req", 64'(bus.dmi_req_o), 64'(r_a));
        step();
        bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = {32'h2, 2'b00};
        @(negedge clk);
        step();
        bus.dmi_resp_valid_i = 0;
        @(negedge clk);
        chk("single_resp0_valid", 64'(bus.resp0_valid_o), 64'(1));
        chk("single_resp0", 64'(bus.resp0_o), 64'(34'h000000008));
        chk("single_resp1_valid", 64'(bus.resp1_valid_o), 64'(0));
        step();
        bus.resp0_ready_i = 1;
        @(negedge clk);
        step();
        bus.resp0_ready_i = 0;

        // Backpressure on dm_top request and on channel 0 response.
        r_a = RW'({$urandom(), $urandom()});
        d_a = PW'({$urandom(), $urandom()});
        bus.req0_valid_i = 1; bus.req0_i = r_a;
        wait_for(W_R0, "bp_accept");
        step();
        bus.req0_valid_i = 0;
        repeat (10) begin
            @(negedge clk);
            chk("bp_dmi_valid", 64'(bus.dmi_req_valid_o), 64'(1));
            chk("bp_dmi_req", 64'(bus.dmi_req_o), 64'(r_a));
        end
        step();
        bus.dmi_req_ready_i = 1;
        @(negedge clk);
        step();
        bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = d_a;
        @(negedge clk);
        step();
        bus.dmi_resp_valid_i = 0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_resp0_valid", 64'(bus.resp0_valid_o), 64'(1));
            chk("bp_resp0", 64'(bus.resp0_o), 64'(d_a));
        end
        step();
        bus.resp0_ready_i = 1;
        @(negedge clk);
        step();
        bus.resp0_ready_i = 0;

        // Tie straight after reset: channel 0 first, then channel 1.
        reset_n = 0;
        step();
        reset_n = 1;
        r_a = RW'({$urandom(), $urandom()});
        r_b = RW'({$urandom(), $urandom()});
        bus.req0_valid_i = 1; bus.req0_i = r_a;
        bus.req1_valid_i = 1; bus.req1_i = r_b;
        bus.dmi_req_ready_i = 1; bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = PW'($urandom());
        bus.resp0_ready_i = 1; bus.resp1_ready_i = 1;
        wait_for(W_R0, "tie_first");
        chk("tie_first_ch1_ready", 64'(bus.req1_ready_o), 64'(0));
        step();
        bus.req0_valid_i = 0;
        @(negedge clk);
        chk("tie_owner_first", 64'(bus.owner_o), 64'(0));
        wait_for(W_R1, "tie_second");
        step();
        bus.req1_valid_i = 0;
        @(negedge clk);
        chk("tie_owner_second", 64'(bus.owner_o), 64'(1));
        wait_for(W_IDLE, "tie_drain");
        step();
        bus.dmi_req_ready_i = 0; bus.dmi_resp_valid_i = 0;
        bus.resp0_ready_i = 0; bus.resp1_ready_i = 0;

        // Reset while waiting for dm_top; a late response must go nowhere.
        bus.req0_valid_i = 1; bus.req0_i = RW'({$urandom(), $urandom()});
        wait_for(W_R0, "midrst_accept");
        step();
        bus.req0_valid_i = 0; bus.dmi_req_ready_i = 1;
        wait_for(W_DR, "midrst_resp_phase");
        step();
        bus.dmi_req_ready_i = 0; reset_n = 0;
        step();
        reset_n = 1;
        @(negedge clk);
        chk("midrst_busy", 64'(bus.busy_o), 64'(0));
        chk("midrst_owner", 64'(bus.owner_o), 64'(1));
        chk("midrst_valids", 64'({bus.dmi_req_valid_o, bus.dmi_resp_ready_o,
            bus.resp0_valid_o, bus.resp1_valid_o}), 64'(0));
        step();
        bus.dmi_resp_valid_i = 1; bus.dmi_resp_i = PW'($urandom());
        bus.resp0_ready_i = 1; bus.resp1_ready_i = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stray_resp_valids", 64'({bus.resp1_valid_o, bus.resp0_valid_o}), 64'(0));
        end
        step();
        bus.dmi_resp_valid_i = 0; bus.resp0_ready_i = 0; bus.resp1_ready_i = 0;

`ifdef DMI_ARB_TIMEOUT_EN
        // dm_top never answers: a failed response arrives after TO cycles in RESP.
        bus.req0_valid_i = 1; bus.req0_i = RW'({$urandom(), $urandom()});
        wait_for(W_R0, "to_accept");
        step();
        bus.req0_valid_i = 0; bus.dmi_req_ready_i = 1;
        wait_for(W_DR, "to_resp_phase");
        step();
        bus.dmi_req_ready_i = 0;
        n = 0;
        for (int i = 0; i < 3 * TO && !bus.resp0_valid_o; i++) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", 64'(n), 64'(TO));
        chk("to_resp0", 64'(bus.resp0_o), 64'({32'h0, 2'b10}));
        step();
        bus.resp0_ready_i = 1;
        @(negedge clk);
        step();
        bus.resp0_ready_i = 0;
`endif

        // Randomized traffic with random backpressure everywhere, then a drain.
        a0s = acc0; a1s = acc1; d0s = done0; d1s = done1; i0 = 0; i1 = 0;
        for (int c = 0; c < 3500; c++) begin
            @(negedge clk);
            f0 = bus.req0_valid_i && bus.req0_ready_o;
            f1 = bus.req1_valid_i && bus.req1_ready_o;
            fr = bus.dmi_resp_valid_i && bus.dmi_resp_ready_o;
            if (c > 2700 && !bus.req0_valid_i && !bus.req1_valid_i && ph == 0) break;
            step();
            if (f0 || !bus.req0_valid_i) begin
                bus.req0_valid_i = (c < 2700) && ($urandom_range(0, 3) != 0);
                bus.req0_i = RW'({$urandom(), $urandom()});
                if (bus.req0_valid_i) i0++;
            end
            if (f1 || !bus.req1_valid_i) begin
                bus.req1_valid_i = (c < 2700) && ($urandom_range(0, 3) != 0);
                bus.req1_i = RW'({$urandom(), $urandom()});
                if (bus.req1_valid_i) i1++;
            end
            if (fr || !bus.dmi_resp_valid_i) begin
                bus.dmi_resp_valid_i = ($urandom_range(0, 3) != 0);
                bus.dmi_resp_i = PW'({$urandom(), $urandom()});
            end
            bus.dmi_req_ready_i = ($urandom_range(0, 2) != 0);
            bus.resp0_ready_i = 1'($urandom_range(0, 1));
            bus.resp1_ready_i = 1'($urandom_range(0, 1));
        end
        chk("drained", 64'({bus.req0_valid_i, bus.req1_valid_i, ph == 0}), 64'(3'b001));
        chk("accepted0", 64'(acc0 - a0s), 64'(i0));
        chk("accepted1", 64'(acc1 - a1s), 64'(i1));
        chk("delivered0", 64'(done0 - d0s), 64'(i0));
        chk("delivered1", 64'(done1 - d1s), 64'(i1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
